// File: rtl/wb_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : wb_bus_arbiter
// Description : Two-master Wishbone B4 classic round-robin arbiter with a
//               per-transfer ack watchdog that terminates hung cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_bus_arbiter #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 16
) (
  input  logic        clk,
  input  logic        rst,
  // instruction master
  input  logic        i_cyc,
  input  logic        i_stb,
  input  logic        i_we,
  input  logic [31:0] i_adr,
  input  logic [31:0] i_dat_w,
  input  logic [3:0]  i_sel,
  output logic        i_ack,
  output logic        i_err,
  output logic [31:0] i_dat_r,
  // data master
  input  logic        d_cyc,
  input  logic        d_stb,
  input  logic        d_we,
  input  logic [31:0] d_adr,
  input  logic [31:0] d_dat_w,
  input  logic [3:0]  d_sel,
  output logic        d_ack,
  output logic        d_err,
  output logic [31:0] d_dat_r,
  // shared bus
  output logic        m_cyc,
  output logic        m_stb,
  output logic        m_we,
  output logic [31:0] m_adr,
  output logic [31:0] m_dat_w,
  output logic [3:0]  m_sel,
  input  logic        m_ack,
  input  logic        m_err,
  input  logic [31:0] m_dat_r
);

  localparam logic [CNT_W-1:0] C_TIMEOUT = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_D = 2'd1,
    GNT_I = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic             r_last_d;      // 1: data master was granted most recently
  logic [CNT_W-1:0] r_cnt;
  logic             r_timed_out;

  logic w_gnt_d, w_gnt_i;
  logic w_d_req, w_i_req;
  logic w_sel_cyc, w_sel_stb;
  logic w_stb_live, w_timeout, w_kill;

  assign w_gnt_d = (r_state == GNT_D);
  assign w_gnt_i = (r_state == GNT_I);
  assign w_d_req = d_cyc & d_stb;
  assign w_i_req = i_cyc & i_stb;

  assign w_sel_cyc = (w_gnt_d & d_cyc) | (w_gnt_i & i_cyc);
  assign w_sel_stb = (w_gnt_d & d_cyc & d_stb) | (w_gnt_i & i_cyc & i_stb);

  // A terminating ack/err in the expiry cycle takes precedence over the watchdog.
  assign w_stb_live = w_sel_stb & ~r_timed_out;
  assign w_timeout  = w_stb_live & ~m_ack & ~m_err & (r_cnt == C_TIMEOUT);
  assign w_kill     = r_timed_out | w_timeout;

  assign m_cyc   = w_sel_cyc & ~w_kill;
  assign m_stb   = w_sel_stb & ~w_kill;
  assign m_we    = w_gnt_d ? d_we    : (w_gnt_i ? i_we    : 1'b0);
  assign m_adr   = w_gnt_d ? d_adr   : (w_gnt_i ? i_adr   : 32'd0);
  assign m_dat_w = w_gnt_d ? d_dat_w : (w_gnt_i ? i_dat_w : 32'd0);
  assign m_sel   = w_gnt_d ? d_sel   : (w_gnt_i ? i_sel   : 4'd0);

  // Terminations arriving after a watchdog expiry belong to a dead cycle.
  assign i_ack   = w_gnt_i & m_ack & ~r_timed_out;
  assign d_ack   = w_gnt_d & m_ack & ~r_timed_out;
  assign i_err   = w_gnt_i & ((m_err & ~r_timed_out) | w_timeout);
  assign d_err   = w_gnt_d & ((m_err & ~r_timed_out) | w_timeout);
  assign i_dat_r = m_dat_r;
  assign d_dat_r = m_dat_r;

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (w_d_req && (!w_i_req || !r_last_d)) begin
          w_next_state = GNT_D;
        end else if (w_i_req) begin
          w_next_state = GNT_I;
        end
      end
      GNT_D:   if (!d_cyc) w_next_state = IDLE;
      GNT_I:   if (!i_cyc) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= IDLE;
      r_last_d <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (r_state == IDLE && w_next_state == GNT_D) begin
        r_last_d <= 1'b1;
      end else if (r_state == IDLE && w_next_state == GNT_I) begin
        r_last_d <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt       <= '0;
      r_timed_out <= 1'b0;
    end else begin
      if (r_state == IDLE || !m_stb || m_ack || m_err) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (r_state == IDLE) begin
        r_timed_out <= 1'b0;
      end else if (w_timeout) begin
        r_timed_out <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_wb_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_bus_arbiter
// Description : Directed self-checking bench for wb_bus_arbiter (TIMEOUT=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_cyc, i_stb, i_we;
  logic [31:0] i_adr, i_dat_w;
  logic [3:0]  i_sel;
  logic        i_ack, i_err;
  logic [31:0] i_dat_r;
  logic        d_cyc, d_stb, d_we;
  logic [31:0] d_adr, d_dat_w;
  logic [3:0]  d_sel;
  logic        d_ack, d_err;
  logic [31:0] d_dat_r;
  logic        m_cyc, m_stb, m_we;
  logic [31:0] m_adr, m_dat_w;
  logic [3:0]  m_sel;
  logic        m_ack, m_err;
  logic [31:0] m_dat_r;

  int n_tests = 0;
  int n_fail  = 0;

  wb_bus_arbiter #(.TIMEOUT(4), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst),
    .i_cyc(i_cyc), .i_stb(i_stb), .i_we(i_we), .i_adr(i_adr), .i_dat_w(i_dat_w),
    .i_sel(i_sel), .i_ack(i_ack), .i_err(i_err), .i_dat_r(i_dat_r),
    .d_cyc(d_cyc), .d_stb(d_stb), .d_we(d_we), .d_adr(d_adr), .d_dat_w(d_dat_w),
    .d_sel(d_sel), .d_ack(d_ack), .d_err(d_err), .d_dat_r(d_dat_r),
    .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_adr(m_adr), .m_dat_w(m_dat_w),
    .m_sel(m_sel), .m_ack(m_ack), .m_err(m_err), .m_dat_r(m_dat_r)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Entered one cycle into a grant; acks it, releases, and re-requests after IDLE.
  task automatic serve(input string tag, input logic [31:0] exp_adr, input logic exp_d);
    check({tag, "_cyc"}, 32'(m_cyc), 32'd1);
    check({tag, "_adr"}, m_adr, exp_adr);
    m_ack = 1'b1;
    #1;
    check({tag, "_dack"}, 32'(d_ack), 32'(exp_d));
    check({tag, "_iack"}, 32'(i_ack), 32'(!exp_d));
    step();
    m_ack = 1'b0;
    if (exp_d) begin d_cyc = 1'b0; d_stb = 1'b0; end
    else       begin i_cyc = 1'b0; i_stb = 1'b0; end
    #1;
    check({tag, "_drop"}, 32'(m_cyc), 32'd0);
    step();
    if (exp_d) begin d_cyc = 1'b1; d_stb = 1'b1; end
    else       begin i_cyc = 1'b1; i_stb = 1'b1; end
    #1;
    check({tag, "_turn"}, 32'(m_cyc), 32'd0);
    step();
  endtask

  initial begin
    rst = 1'b0;
    i_cyc = 0; i_stb = 0; i_we = 0; i_adr = 32'h1000_0000; i_dat_w = 0; i_sel = 4'hF;
    d_cyc = 0; d_stb = 0; d_we = 1; d_adr = 32'h2000_0000; d_dat_w = 32'hFFFF; d_sel = 4'hF;
    m_ack = 0; m_err = 0; m_dat_r = 32'h0000_CAFE;
    #2;
    // reset: outputs quiet, read data passes through
    check("rst_mcyc", 32'(m_cyc), 32'd0);
    check("rst_madr", m_adr, 32'd0);
    check("rst_mdatw", m_dat_w, 32'd0);
    check("rst_msel", 32'(m_sel), 32'd0);
    check("rst_mwe", 32'(m_we), 32'd0);
    check("rst_idatr", i_dat_r, 32'h0000_CAFE);
    step();
    step();
    rst = 1'b1;
    d_we = 0;

    // tie out of reset, then alternation with both requesting continuously
    i_cyc = 1; i_stb = 1; d_cyc = 1; d_stb = 1;
    #1;
    check("tie_idle", 32'(m_cyc), 32'd0);
    step();
    serve("rr1_d", 32'h2000_0000, 1'b1);
    serve("rr2_i", 32'h1000_0000, 1'b0);
    serve("rr3_d", 32'h2000_0000, 1'b1);
    serve("rr4_i", 32'h1000_0000, 1'b0);
    check("rr5_adr", m_adr, 32'h2000_0000);
    i_cyc = 0; i_stb = 0; d_cyc = 0; d_stb = 0;
    step();
    step();

    // single I read, ack two cycles after strobe
    i_cyc = 1; i_stb = 1; i_adr = 32'h0000_0100;
    step();
    check("rd_cyc", 32'(m_cyc), 32'd1);
    check("rd_adr", m_adr, 32'h0000_0100);
    check("rd_iack0", 32'(i_ack), 32'd0);
    step();
    check("rd_iack1", 32'(i_ack), 32'd0);
    step();
    m_ack = 1; m_dat_r = 32'hDEAD_BEEF;
    #1;
    check("rd_iack", 32'(i_ack), 32'd1);
    check("rd_idatr", i_dat_r, 32'hDEAD_BEEF);
    check("rd_dack", 32'(d_ack), 32'd0);
    step();
    m_ack = 0; i_cyc = 0; i_stb = 0;
    #1;
    check("rd_iack_end", 32'(i_ack), 32'd0);
    check("rd_mcyc_end", 32'(m_cyc), 32'd0);
    step();
    step();

    // D store while I request is held behind it
    d_cyc = 1; d_stb = 1; d_we = 1; d_adr = 32'h2000_0004; d_dat_w = 32'h1234_5678; d_sel = 4'b0011;
    step();
    i_cyc = 1; i_stb = 1; i_adr = 32'h0000_0300; i_we = 0;
    #1;
    check("st_we", 32'(m_we), 32'd1);
    check("st_adr", m_adr, 32'h2000_0004);
    check("st_datw", m_dat_w, 32'h1234_5678);
    check("st_sel", 32'(m_sel), 32'h3);
    check("st_stb", 32'(m_stb), 32'd1);
    step();
    step();
    m_ack = 1;
    #1;
    check("st_dack", 32'(d_ack), 32'd1);
    check("st_iack", 32'(i_ack), 32'd0);
    step();
    m_ack = 0; d_cyc = 0; d_stb = 0;
    #1;
    check("st_drop", 32'(m_cyc), 32'd0);
    step();
    check("st_turn", 32'(m_cyc), 32'd0);
    step();
    check("igr_adr", m_adr, 32'h0000_0300);
    check("igr_we", 32'(m_we), 32'd0);
    check("igr_cyc", 32'(m_cyc), 32'd1);

    // abort: granted I drops cyc mid-wait
    step();
    i_cyc = 0; i_stb = 0;
    #1;
    check("abort_mcyc", 32'(m_cyc), 32'd0);
    step();
    d_cyc = 1; d_stb = 1; d_we = 0;
    step();
    check("abort_idle_regrant", 32'(m_cyc), 32'd1);

    // watchdog: slave never acks D
    check("to_c1_err", 32'(d_err), 32'd0);
    for (int k = 2; k <= 4; k++) begin
      step();
      check($sformatf("to_c%0d_err", k), 32'(d_err), 32'd0);
      check($sformatf("to_c%0d_cyc", k), 32'(m_cyc), 32'd1);
    end
    step();
    check("to_c5_err", 32'(d_err), 32'd1);
    check("to_c5_cyc", 32'(m_cyc), 32'd0);
    check("to_c5_stb", 32'(m_stb), 32'd0);
    step();
    check("to_c6_err", 32'(d_err), 32'd0);
    check("to_c6_cyc", 32'(m_cyc), 32'd0);
    m_ack = 1;
    #1;
    check("to_late_ack", 32'(d_ack), 32'd0);
    m_ack = 0; d_cyc = 0; d_stb = 0;
    step();

    // ack in the cycle the count reaches TIMEOUT wins
    i_cyc = 1; i_stb = 1; i_adr = 32'h0000_0400;
    step();
    check("aw_c1_cyc", 32'(m_cyc), 32'd1);
    step();
    step();
    step();
    step();
    m_ack = 1;
    #1;
    check("aw_iack", 32'(i_ack), 32'd1);
    check("aw_ierr", 32'(i_err), 32'd0);
    check("aw_cyc", 32'(m_cyc), 32'd1);
    step();
    m_ack = 0;
    #1;
    check("aw_next_err", 32'(i_err), 32'd0);
    check("aw_next_cyc", 32'(m_cyc), 32'd1);
    i_cyc = 0; i_stb = 0;
    step();

    // async reset mid-transfer, then tie after release goes to D
    d_cyc = 1; d_stb = 1; d_adr = 32'h2000_0008;
    step();
    check("ar_pre_cyc", 32'(m_cyc), 32'd1);
    #2;
    rst = 0;
    #1;
    check("ar_cyc", 32'(m_cyc), 32'd0);
    check("ar_adr", m_adr, 32'd0);
    i_cyc = 1; i_stb = 1;
    step();
    check("ar_hold_cyc", 32'(m_cyc), 32'd0);
    rst = 1;
    step();
    check("ar_tie_adr", m_adr, 32'h2000_0008);
    check("ar_tie_cyc", 32'(m_cyc), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
